// File: rtl/vec_mem_seq_pkg.sv
// Shared types and constants for the vector memory/add sequencer.
package vec_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        OP_VLOAD  = 2'b00,
        OP_VSTORE = 2'b01,
        OP_VADD   = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BASE,
        S_RD_ADDR,
        S_RD_CAPT,
        S_WR_BEAT,
        S_ADD_SUM,
        S_VWB
    } state_e;

    localparam logic [2:0] MEMIN_R1 = 3'b100;

endpackage

// File: rtl/vec_mem_seq_if.sv
// Handshake with the main FSM plus the datapath strobes driven by the sequencer.
interface vec_mem_seq_if #(
    parameter int LANES = vec_pkg::LANES
);
    logic             start;
    logic [1:0]       op;
    logic             busy;
    logic             done;
    logic             mem_own;
    logic             MemRead;
    logic             MemWrite;
    logic [2:0]       MemIn;
    logic             R2Sel;
    logic             R2Ld;
    logic             X1Load;
    logic             X2Load;
    logic             VoutSel;
    logic [LANES-1:0] TLd;
    logic             VRFWrite;

    modport master (
        output start, op,
        input  busy, done, mem_own, MemRead, MemWrite, MemIn, R2Sel, R2Ld,
               X1Load, X2Load, VoutSel, TLd, VRFWrite
    );

    modport slave (
        input  start, op,
        output busy, done, mem_own, MemRead, MemWrite, MemIn, R2Sel, R2Ld,
               X1Load, X2Load, VoutSel, TLd, VRFWrite
    );

endinterface

// File: rtl/vec_mem_seq_lane_onehot.sv
// Beat index to lane enable, MSB-first: index 0 selects the top bit (lane T0).
module lane_onehot #(
    parameter int LANES = 4,
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [LANES-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < LANES; i++) begin
            o_onehot[LANES-1-i] = (int'(i_idx) == i);
        end
    end

endmodule

// File: rtl/vec_mem_seq.sv
// Sequencer for VLOAD/VSTORE/VADD: Moore-decodes datapath strobes from state and beat.
//
//   state   | meaning
//   IDLE    | waiting for start; scalar path owns memory input mux
//   BASE    | load R2 base and/or X operands for the latched op
//   RD_ADDR | present R2 to memory, read strobe
//   RD_CAPT | capture read data into one T lane, advance R2
//   WR_BEAT | write one X1 lane at R2, advance R2
//   ADD_SUM | load all T lanes from the adder
//   VWB     | write T lanes to the VRF, finish
module vec_mem_seq
    import vec_pkg::*;
#(
    parameter int LANES = vec_pkg::LANES
) (
    input  logic          clock,
    input  logic          reset,
    vec_mem_seq_if.slave  bus
);

    localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [BEAT_W-1:0]  r_beat;
    logic [BEAT_W-1:0]  w_beat_nxt;
    op_e                r_op;
    logic               w_last_beat;
    logic [LANES-1:0]   w_lane_oh;

    lane_onehot #(
        .LANES (LANES),
        .IDX_W (BEAT_W)
    ) u_lane_onehot (
        .i_idx    (r_beat),
        .o_onehot (w_lane_oh)
    );

    assign w_last_beat = (r_beat == BEAT_W'(LANES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_op    <= OP_VLOAD;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (r_state == S_IDLE && bus.start) begin
                r_op <= op_e'(bus.op);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = r_beat;
        bus.busy     = (r_state != S_IDLE);
        bus.done     = 1'b0;
        bus.mem_own  = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.MemIn    = MEMIN_R1;
        bus.R2Sel    = 1'b0;
        bus.R2Ld     = 1'b0;
        bus.X1Load   = 1'b0;
        bus.X2Load   = 1'b0;
        bus.VoutSel  = 1'b1;
        bus.TLd      = '0;
        bus.VRFWrite = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_beat_nxt = '0;
                if (bus.start) begin
                    w_state_nxt = S_BASE;
                end
            end
            S_BASE: begin
                case (r_op)
                    OP_VLOAD: begin
                        bus.R2Ld    = 1'b1;
                        w_state_nxt = S_RD_ADDR;
                    end
                    OP_VSTORE: begin
                        bus.R2Ld    = 1'b1;
                        bus.X1Load  = 1'b1;
                        w_state_nxt = S_WR_BEAT;
                    end
                    OP_VADD: begin
                        bus.X1Load  = 1'b1;
                        bus.X2Load  = 1'b1;
                        w_state_nxt = S_ADD_SUM;
                    end
                    default: begin
                        bus.done    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
            S_RD_ADDR: begin
                bus.mem_own = 1'b1;
                bus.MemRead = 1'b1;
                w_state_nxt = S_RD_CAPT;
            end
            S_RD_CAPT: begin
                bus.TLd   = w_lane_oh;
                bus.R2Ld  = 1'b1;
                bus.R2Sel = 1'b1;
                if (w_last_beat) begin
                    w_beat_nxt  = '0;
                    w_state_nxt = S_VWB;
                end else begin
                    w_beat_nxt  = r_beat + 1'b1;
                    w_state_nxt = S_RD_ADDR;
                end
            end
            S_WR_BEAT: begin
                bus.mem_own  = 1'b1;
                bus.MemWrite = 1'b1;
                bus.MemIn    = 3'(r_beat);
                bus.R2Ld     = 1'b1;
                bus.R2Sel    = 1'b1;
                if (w_last_beat) begin
                    bus.done    = 1'b1;
                    w_beat_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_beat_nxt  = r_beat + 1'b1;
                end
            end
            S_ADD_SUM: begin
                bus.TLd     = '1;
                bus.VoutSel = 1'b0;
                w_state_nxt = S_VWB;
            end
            S_VWB: begin
                bus.VRFWrite = 1'b1;
                bus.done     = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_beat_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Bench for vec_mem_seq: a behavioural datapath (R2, X1/X2, T lanes, memory, VRF) is
// steered by the DUT strobes and its results are compared with plain vector arithmetic.
module tb_vec_mem_seq;

    logic clock;
    logic reset;

    vec_mem_seq_if #(.LANES(4)) bus ();

    vec_mem_seq #(.LANES(4)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL timeout global_time_limit");
        $fatal(1, "time limit");
    end

    int n_chk = 0;
    int n_err = 0;

    // datapath model state
    logic [7:0]  mem [256];
    logic [7:0]  mem_snap [256];
    logic [7:0]  m_r2;
    logic [7:0]  m_rdata;
    logic [31:0] m_x1, m_x2, m_t;
    logic [31:0] vrf_dest;
    logic [7:0]  rf_base;
    logic [31:0] vreg_a, vreg_b;

    // per-operation observations
    int          op_cyc, busy_cnt, done_cnt, done_cyc, vrfw_cyc, wr_cnt, strb_cnt, viol;
    logic [7:0]  rd_q[$];
    logic [3:0]  tld_q[$];

    localparam logic [17:0] IDLE_VEC = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100,
                                        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lane(input logic [31:0] v, input int i);
        return v[31-8*i -: 8];
    endfunction

    function automatic logic [17:0] outs();
        return {bus.busy, bus.done, bus.mem_own, bus.MemRead, bus.MemWrite, bus.MemIn,
                bus.R2Sel, bus.R2Ld, bus.X1Load, bus.X2Load, bus.VoutSel, bus.TLd, bus.VRFWrite};
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
        case (op)
            2'b00:   return 10;
            2'b01:   return 5;
            2'b10:   return 3;
            default: return 1;
        endcase
    endfunction

    task automatic clear_obs();
        op_cyc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0; vrfw_cyc = 0;
        wr_cnt = 0; strb_cnt = 0; viol = 0;
        rd_q.delete();
        tld_q.delete();
    endtask

    // Effect of one rising edge on the datapath, given the strobes seen this cycle.
    task automatic model_step();
        logic [7:0]  n_r2, n_rdata;
        logic [31:0] n_x1, n_x2, n_t;
        n_r2 = m_r2; n_rdata = m_rdata; n_x1 = m_x1; n_x2 = m_x2; n_t = m_t;
        if (bus.busy) begin
            op_cyc++;
            busy_cnt++;
        end
        if (bus.MemRead) begin
            rd_q.push_back(m_r2);
            n_rdata = mem[m_r2];
        end
        if (bus.MemWrite) begin
            mem[m_r2] = lane(m_x1, int'(bus.MemIn[1:0]));
            wr_cnt++;
            if (bus.MemIn[2]) viol++;
        end
        if ((bus.MemRead || bus.MemWrite) && !bus.mem_own) viol++;
        if (bus.R2Ld)   n_r2 = bus.R2Sel ? m_r2 + 8'd1 : rf_base;
        if (bus.X1Load) n_x1 = vreg_a;
        if (bus.X2Load) n_x2 = vreg_b;
        if (bus.TLd != 4'b0000) tld_q.push_back(bus.TLd);
        for (int i = 0; i < 4; i++) begin
            if (bus.TLd[3-i]) n_t[31-8*i -: 8] = bus.VoutSel ? m_rdata : lane(m_x1, i) + lane(m_x2, i);
        end
        if (bus.VRFWrite) begin
            vrf_dest = m_t;
            vrfw_cyc = op_cyc;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = op_cyc;
        end
        if (bus.MemRead || bus.MemWrite || bus.R2Ld || bus.X1Load || bus.X2Load ||
            bus.VRFWrite || (bus.TLd != 4'b0000)) strb_cnt++;
        m_r2 = n_r2; m_rdata = n_rdata; m_x1 = n_x1; m_x2 = n_x2; m_t = n_t;
    endtask

    task automatic cycle();
        @(negedge clock);
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] base, input logic [31:0] a,
                          input logic [31:0] b, input int restart_at);
        logic [31:0] vrf_before, exp_v;
        logic [7:0]  ad;
        int          lat, k;
        rf_base = base; vreg_a = a; vreg_b = b;
        for (int i = 0; i < 256; i++) mem_snap[i] = mem[i];
        vrf_before = vrf_dest;
        lat = exp_lat(op);
        clear_obs();
        bus.start = 1'b1;
        bus.op    = op;
        cycle();
        bus.start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 20) begin
            bus.start = (op_cyc + 1 == restart_at);
            if (bus.start) bus.op = 2'($urandom);
            cycle();
            k++;
        end
        bus.start = 1'b0;
        chk("done_seen", 32'(done_cnt), 32'd1);
        chk("busy_cycles", 32'(busy_cnt), 32'(lat));
        chk("done_cycle", 32'(done_cyc), 32'(lat));
        chk("idle_after_done", 32'(bus.busy), 32'd0);
        chk("own_memin_viol", 32'(viol), 32'd0);
        case (op)
            2'b00: begin
                exp_v = '0;
                for (int i = 0; i < 4; i++) begin
                    ad = base + 8'(i);
                    exp_v[31-8*i -: 8] = mem_snap[ad];
                end
                chk("vload_nreads", 32'(rd_q.size()), 32'd4);
                for (int i = 0; i < rd_q.size() && i < 4; i++) chk("vload_addr", 32'(rd_q[i]), 32'(base + 8'(i)));
                chk("vload_ntld", 32'(tld_q.size()), 32'd4);
                for (int i = 0; i < tld_q.size() && i < 4; i++) chk("vload_tld", 32'(tld_q[i]), 32'(4'b1000 >> i));
                chk("vload_vrfw_cyc", 32'(vrfw_cyc), 32'(lat));
                chk("vload_vrf", vrf_dest, exp_v);
                chk("vload_writes", 32'(wr_cnt), 32'd0);
            end
            2'b01: begin
                chk("vstore_writes", 32'(wr_cnt), 32'd4);
                for (int i = 0; i < 4; i++) begin
                    ad = base + 8'(i);
                    chk("vstore_mem", 32'(mem[ad]), 32'(lane(a, i)));
                end
                chk("vstore_reads", 32'(rd_q.size()), 32'd0);
                chk("vstore_vrf_kept", vrf_dest, vrf_before);
            end
            2'b10: begin
                exp_v = '0;
                for (int i = 0; i < 4; i++) exp_v[31-8*i -: 8] = lane(a, i) + lane(b, i);
                chk("vadd_ntld", 32'(tld_q.size()), 32'd1);
                if (tld_q.size() > 0) chk("vadd_tld", 32'(tld_q[0]), 32'hF);
                chk("vadd_vrfw_cyc", 32'(vrfw_cyc), 32'd3);
                chk("vadd_vrf", vrf_dest, exp_v);
                chk("vadd_memacc", 32'(rd_q.size() + wr_cnt), 32'd0);
            end
            default: begin
                chk("rsvd_strobes", 32'(strb_cnt), 32'd0);
                chk("rsvd_vrf_kept", vrf_dest, vrf_before);
            end
        endcase
    endtask

    initial begin
        logic [1:0]  rop;
        logic [7:0]  old_b1;
        int          ra;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.op = 2'b00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        m_r2 = '0; m_rdata = '0; m_x1 = '0; m_x2 = '0; m_t = '0; vrf_dest = '0;
        rf_base = '0; vreg_a = '0; vreg_b = '0;
        clear_obs();

        #2;
        chk("reset_async_outs", 32'(outs()), 32'(IDLE_VEC));
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("reset_outs", 32'(outs()), 32'(IDLE_VEC));
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("idle_outs", 32'(outs()), 32'(IDLE_VEC));
        end

        mem[8'h20] = 8'hAA; mem[8'h21] = 8'hBB; mem[8'h22] = 8'hCC; mem[8'h23] = 8'hDD;
        run_op(2'b00, 8'h20, 32'h0, 32'h0, 0);
        chk("vload_const", vrf_dest, 32'hAABBCCDD);
        run_op(2'b00, 8'h20, 32'h0, 32'h0, 4);
        chk("vload_restart_const", vrf_dest, 32'hAABBCCDD);

        run_op(2'b01, 8'hFE, 32'h11223344, 32'h0, 0);
        chk("vstore_wrap_const", {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}, 32'h11223344);

        run_op(2'b10, 8'h00, 32'h01020304, 32'h10FF2030, 0);
        chk("vadd_const", vrf_dest, 32'h11012334);

        run_op(2'b11, 8'h55, 32'h0, 32'h0, 0);
        run_op(2'b11, 8'h55, 32'h0, 32'h0, 1);

        // abort a VSTORE while beat 1 is presenting its write
        rf_base = 8'h40; vreg_a = 32'hDEADBEEF;
        old_b1 = mem[8'h41];
        clear_obs();
        bus.start = 1'b1; bus.op = 2'b01;
        cycle();
        bus.start = 1'b0;
        cycle();
        cycle();
        chk("abort_mw_before", 32'(bus.MemWrite), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_mw_async", 32'(bus.MemWrite), 32'd0);
        chk("abort_outs_async", 32'(outs()), 32'(IDLE_VEC));
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        chk("abort_outs_after", 32'(outs()), 32'(IDLE_VEC));
        chk("abort_writes", 32'(wr_cnt), 32'd1);
        chk("abort_beat0", 32'(mem[8'h40]), 32'hDE);
        chk("abort_beat1_kept", 32'(mem[8'h41]), 32'(old_b1));
        run_op(2'b10, 8'h00, 32'h80808080, 32'h80017F01, 0);

        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, exp_lat(rop))) : 0;
            run_op(rop, 8'($urandom), $urandom, $urandom, ra);
            if ($urandom_range(0, 3) == 0) cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vec_mem_seq.md
Name: vec_mem_seq

Overview:
- Control sequencer for the vector extension of the 8-bit multicycle processor; sits directly upstream of the vector datapath (R2 address register, T0–T3 lane registers, X1/X2 operand registers, VRF, data-memory input mux).
- The main FSM hands it one vector operation (VLOAD, VSTORE or VADD) through a start/done handshake.
- It then drives the per-beat memory, lane-load and writeback strobes until the 32-bit vector transfer or add completes.
- Control returns to the main FSM after done.

Parameters:
- LANES, 4, number of 8-bit lanes per vector; fixes beat count and beat counter width.
- LANE_W, 8, lane and memory data width; documentary only, no datapath inside the block.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the block to IDLE immediately.
- start  in  1  one-cycle request from the main FSM; sampled only in IDLE.
- op  in  2  operation code: 00 VLOAD, 01 VSTORE, 10 VADD, 11 reserved.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse during the final active cycle of an operation.
- mem_own  out  1  high while the sequencer owns the memory address; top level forces AddrSel to the R2 path.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemIn  out  3  data-memory input mux select: 000..011 select X1 lane 0..3; 100 selects R1 (scalar path).
- R2Sel  out  1  0 = load base address from RF port 2; 1 = load R2+1.
- R2Ld  out  1  R2 address register enable.
- X1Load  out  1  X1 operand register enable.
- X2Load  out  1  X2 operand register enable.
- VoutSel  out  1  T-lane mux select: 0 = adder outputs, 1 = memory data.
- TLd  out  LANES  per-lane T register enables; bit 3 = T0 (MSB lane), bit 0 = T3.
- VRFWrite  out  1  vector register file write enable.

Behaviour:
- Reset (reset=0): state IDLE, beat counter 0.
  - All strobes 0.
  - MemIn=100, so scalar stores are unaffected.
  - Reset mid-operation aborts immediately; a MemWrite in flight deasserts asynchronously.
  - No partial VRF write occurs, because VRFWrite is only issued in the final state.
- All outputs are Moore-decoded from state and beat; there are no registered output copies.
- States:
  - IDLE: start=1 moves to BASE with op latched into op_q.
  - BASE, common to all ops:
    - VLOAD: R2Ld=1, R2Sel=0.
    - VSTORE: R2Ld=1, R2Sel=0, X1Load=1.
    - VADD: X1Load=1, X2Load=1.
    - reserved: done=1, return to IDLE.
  - VLOAD beats, beat=0..3:
    - RD_ADDR: mem_own=1, MemRead=1.
    - RD_CAPT: TLd one-hot for lane beat (beat0 → T0), VoutSel=1, R2Ld=1, R2Sel=1.
    - After beat 3 go to VWB; otherwise beat+1 and return to RD_ADDR.
  - VSTORE, WR_BEAT beat=0..3: mem_own=1, MemWrite=1, MemIn=beat, R2Ld=1, R2Sel=1. At beat 3, done=1 and return to IDLE.
  - VADD, ADD_SUM: TLd=1111, VoutSel=0, then VWB.
  - VWB: VRFWrite=1, done=1, return to IDLE.
- Latency in busy cycles, start cycle excluded: VLOAD 10, VSTORE 5, VADD 3, reserved 1.
- start during busy is ignored and not queued. start in the same cycle done is high is also ignored; the block is not yet in IDLE.
- Addresses wrap 8'hFF → 8'h00 through the R2+1 path; no special handling.
- Memory read latency is 1 clock: data is valid in RD_CAPT for the address presented in RD_ADDR.
- VoutSel holds 1 outside ADD_SUM; it is only meaningful when a TLd bit is set.

Decomposition:
- Shared package vec_pkg:
  - op codes OP_VLOAD/OP_VSTORE/OP_VADD/OP_RSVD.
  - State encoding: IDLE, BASE, RD_ADDR, RD_CAPT, WR_BEAT, ADD_SUM, VWB.
  - MEMIN_R1=3'b100.
- One natural sub-module, lane_onehot: beat index → LANES-wide one-hot, MSB-first. Used for TLd.

Test Plan:
- Reset then idle: reset=0 for 2 cycles → busy=0, all strobes 0, MemIn=100. Release, hold start=0 for 5 cycles → outputs unchanged.
- VLOAD, base 8'h20, memory 20..23 = AA BB CC DD:
  - Pulse start, op=00 → busy 10 cycles.
  - MemRead addresses 20,21,22,23.
  - TLd sequence 1000, 0100, 0010, 0001.
  - VRFWrite in cycle 10, with done in the same cycle.
  - VRF dest = AABBCCDD.
- VSTORE, X1=11223344, base 8'hFE: writes 11@FE, 22@FF, 33@00, 44@01 (wrap). MemIn 000..011, done at cycle 5.
- VADD, vregs 01020304 + 10FF2030: TLd=1111 in cycle 2, VRFWrite in cycle 3, result 11012334 (lane wrap FF+02=01). done=1 in cycle 3.
- Robustness:
  - Assert start again at VLOAD cycle 4 → ignored; exactly 10 busy cycles.
  - op=11 → busy 1 cycle, done=1, no strobes.
- Reset mid-op: reset=0 during VSTORE beat 1 → MemWrite falls immediately, state IDLE, no further writes. A subsequent VADD completes normally.
